mips_dmem_responder: RTL and testbench
======================================

Name: mips_dmem_responder

Overview:
- Data-memory responder serving the MIPS CPU's load/store port over a valid/ready request/response handshake.
- Word-addressed internal array with byte enables, configurable access latency and an error response for illegal addresses.
- Exposes a debug read port so the top-level bench can inspect main-memory contents without disturbing traffic.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- LATENCY, 2, cycles from request acceptance to first rsp_valid; must be 1 to 15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- dbg_addr  in  log2(DEPTH_WORDS)  debug word index.
- dbg_data  out  32  combinational read of array[dbg_addr].

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: req_ready=0 while rst_n=0, then 1 in the first cycle after release; rsp_valid=0; rsp_rdata=0; rsp_err=0; FSM=IDLE; latency counter=0.
- Array contents are not reset; they are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid && req_ready at a rising edge.
  - On accept, go to RESP if LATENCY==1; otherwise go to WAIT with counter=LATENCY-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - Go to RESP on the edge where counter==1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready.
  - On that edge go to IDLE with rsp_valid=0 and rsp_rdata=0.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Throughput: one outstanding transaction. The next accept can occur no earlier than the cycle after the response handshake.
- Address check at accept:
  - err if req_addr[1:0]!=0.
  - err if req_addr < BASE_ADDR or req_addr >= BASE_ADDR+DEPTH_WORDS*4.
  - Word index = (req_addr-BASE_ADDR)>>2.
- Store, no error: on the accept edge, array[idx] byte lanes with req_be=1 take req_wdata; other lanes are unchanged. req_be=0 is a legal no-op store and still gets a response.
- Load, no error: read data is captured on the accept edge and held in a register until the response.
- Errored access: the array is untouched, rsp_err=1, rsp_rdata=0.
- Store response: rsp_valid with rsp_rdata=0 and rsp_err=0.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Debug port vs. store: if dbg_addr equals a store's index on its accept edge, dbg_data shows the new value from the next cycle.
- Request inputs are ignored whenever req_ready=0; there is no queuing.
- Reset mid-transaction: the transaction is abandoned and no response is produced. A store already committed on its accept edge stays committed.

Decomposition:
- Shared package mips_mem_pkg:
  - Response-code constants RSP_OK and RSP_ERR.
  - Byte-enable width constant MEM_BE_W=4.
  - State enum dmem_state_t {IDLE, WAIT, RESP}.
- One natural sub-module, mips_dmem_array:
  - Byte-enabled single-write-port word array.
  - One synchronous read port for the request path and one combinational read port for debug.
- FSM, address check and latency counter stay in the top module.

Test Plan:
- Latency: LATENCY=2, store addr 0x10 data 0xDEADBEEF be=4'hF, then load 0x10 -> store response rsp_err=0 rsp_rdata=0 exactly 2 cycles after accept; load returns 0xDEADBEEF 2 cycles after its accept.
- Byte enables: word 0x20 holds 0x11223344, store 0xAABBCCDD be=4'b0101 -> load returns 0x11BB33DD; dbg_addr=8 shows the same value.
- Error: load 0x22 (misaligned) -> rsp_err=1, rsp_rdata=0. Store to BASE_ADDR+DEPTH_WORDS*4 -> rsp_err=1, no array word changes.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load of 0x55AA55AA -> rsp_valid, rsp_rdata and rsp_err stable throughout, req_ready=0; accept completes on the first rsp_ready=1 edge.
- Boundaries: LATENCY=1 -> rsp_valid the cycle after accept. Load of the last valid word (BASE_ADDR+DEPTH_WORDS*4-4) -> no error.
- Reset: assert rst_n=0 while in WAIT -> rsp_valid=0 immediately and no response after release; a later load of an address stored before the reset returns the stored data.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared constants and state type for the MIPS data-memory responder
package mips_mem_pkg;
  localparam logic RSP_OK = 1'b0;
  localparam logic RSP_ERR = 1'b1;
  localparam int MEM_BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/mips_dmem_array.sv
// mips_dmem_array: byte-enabled word array with a registered request read port and a combinational debug port
module mips_dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [31:0]         wdata,
  input  logic [MEM_BE_W-1:0] be,
  output logic [31:0]         rdata,
  input  logic [AW-1:0]       dbg_addr,
  output logic [31:0]         dbg_data
);
  logic [31:0] mem [DEPTH_WORDS];
  assign dbg_data = mem[dbg_addr];
  // write enabled lanes and capture load data on the same edge the request is accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_BE_W; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: valid/ready data-memory responder with fixed latency and address error checking
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [31:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
  input  logic [MEM_BE_W-1:0]            req_be,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic                           rsp_err,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic live_q, err_q, load_q, accept, bad;
  logic [31:0] off, rdata;
  assign off = req_addr - BASE_ADDR;
  assign bad = (|req_addr[1:0]) || (req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
  assign req_ready = live_q && state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state_q == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q && !err_q) ? rdata : '0;
  mips_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk),
    .we(accept && req_we && !bad),
    .re(accept && !req_we && !bad),
    .addr(off[AW+1:2]),
    .wdata(req_wdata),
    .be(req_be),
    .rdata(rdata),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );
  // next state: accept in IDLE, count down the remaining latency in WAIT, hold RESP until taken
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (LATENCY == 1) ? RESP : WAIT;
        cnt_d = CNT_INIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, counter and per-transaction response attributes; live_q keeps req_ready low during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      live_q <= 1'b0;
      err_q <= RSP_OK;
      load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      live_q <= 1'b1;
      if (accept) begin
        err_q <= bad ? RSP_ERR : RSP_OK;
        load_q <= !req_we;
      end
    end
  end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: directed table-driven checks of the data-memory responder at latency 2 and 1
module tb_mips_dmem_responder;
  typedef struct packed {
    logic        s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] rd;
    logic        e;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] vld = '0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] be = '0;
  logic rsp_ready = 1'b1;
  logic [7:0] dbg0 = '0;
  logic [3:0] dbg1 = '0;
  logic rdy0, rv0, err0, rdy1, rv1, err1;
  logic [31:0] rd0, rd1, dd0, dd1;
  logic sel = 1'b0;
  logic rdy_m, rv_m, err_m;
  logic [31:0] rd_m;
  int checks = 0;
  int errors = 0;
  vec_t v [19];
  assign rdy_m = sel ? rdy1 : rdy0;
  assign rv_m = sel ? rv1 : rv0;
  assign err_m = sel ? err1 : err0;
  assign rd_m = sel ? rd1 : rd0;
  always #5 clk = ~clk;
  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy0), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(rv0), .rsp_ready(rsp_ready),
    .rsp_rdata(rd0), .rsp_err(err0), .dbg_addr(dbg0), .dbg_data(dd0)
  );
  mips_dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h400)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy1), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_be(be), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_rdata(rd1), .rsp_err(err1), .dbg_addr(dbg1), .dbg_data(dd1)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic issue(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int n;
    sel = s;
    @(negedge clk);
    we = w;
    addr = a;
    wdata = d;
    be = b;
    vld[s] = 1'b1;
    n = 0;
    while (!rdy_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) chk("accept_timeout", 32'(rdy_m), 32'd1);
    @(posedge clk);
    #1 vld = '0;
  endtask
  task automatic collect(output logic [31:0] rd, output logic e, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rv_m && lat < 20);
    if (!rv_m) lat = 99;
    rd = rd_m;
    e = err_m;
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input vec_t t, input string n);
    logic [31:0] rd;
    logic e;
    int lat;
    issue(t.s, t.w, t.a, t.d, t.b);
    collect(rd, e, lat);
    chk({n, "_rdata"}, rd, t.rd);
    chk({n, "_err"}, 32'(e), 32'(t.e));
    chk({n, "_lat"}, 32'(lat), 32'(t.lat));
    chk({n, "_post_valid"}, 32'(rv_m), 32'd0);
  endtask
  initial begin
    int seen;
    v[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2};
    v[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2};
    v[2]  = '{1'b0, 1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0, 2};
    v[3]  = '{1'b0, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2};
    v[4]  = '{1'b0, 1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0, 2};
    v[5]  = '{1'b0, 1'b0, 32'h22,  32'h0,        4'hF, 32'h0,        1'b1, 2};
    v[6]  = '{1'b0, 1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, 2};
    v[7]  = '{1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2};
    v[8]  = '{1'b0, 1'b0, 32'h0,   32'h0,        4'hF, 32'hA5A5A5A5, 1'b0, 2};
    v[9]  = '{1'b0, 1'b1, 32'h3FC, 32'h12345678, 4'hF, 32'h0,        1'b0, 2};
    v[10] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        4'hF, 32'h12345678, 1'b0, 2};
    v[11] = '{1'b0, 1'b1, 32'h30,  32'h01020304, 4'hF, 32'h0,        1'b0, 2};
    v[12] = '{1'b0, 1'b1, 32'h30,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 2};
    v[13] = '{1'b0, 1'b0, 32'h30,  32'h0,        4'hF, 32'h01020304, 1'b0, 2};
    v[14] = '{1'b1, 1'b1, 32'h43C, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0, 1};
    v[15] = '{1'b1, 1'b0, 32'h43C, 32'h0,        4'hF, 32'h0BADCAFE, 1'b0, 1};
    v[16] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        4'hF, 32'h0,        1'b1, 1};
    v[17] = '{1'b1, 1'b0, 32'h440, 32'h0,        4'hF, 32'h0,        1'b1, 1};
    v[18] = '{1'b1, 1'b0, 32'h43E, 32'h0,        4'hF, 32'h0,        1'b1, 1};
    #1;
    chk("rst_req_ready", 32'(rdy0), 32'd0);
    chk("rst_rsp_valid", 32'(rv0), 32'd0);
    chk("rst_rsp_rdata", rd0, 32'h0);
    chk("rst_rsp_err", 32'(err0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(rdy0), 32'd1);
    for (int i = 0; i < 19; i++) xact(v[i], $sformatf("v%0d", i));
    dbg0 = 8'd8;
    #1 chk("dbg_word8", dd0, 32'h11BB33DD);
    dbg0 = 8'd0;
    #1 chk("dbg_word0_untouched", dd0, 32'hA5A5A5A5);
    xact('{1'b0, 1'b1, 32'h14, 32'h0, 4'hF, 32'h0, 1'b0, 2}, "dbg_pre");
    dbg0 = 8'd5;
    #1 chk("dbg_before_store", dd0, 32'h0);
    issue(1'b0, 1'b1, 32'h14, 32'h77778888, 4'hF);
    chk("dbg_after_store", dd0, 32'h77778888);
    begin
      logic [31:0] rd;
      logic e;
      int lat;
      collect(rd, e, lat);
      chk("dbg_store_lat", 32'(lat), 32'd2);
    end
    xact('{1'b0, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 2}, "bp_pre");
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    seen = 0;
    while (!rv0 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        we = 1'b1;
        wdata = 32'h0;
        vld[0] = 1'b1;
      end
      chk($sformatf("bp%0d_valid", c), 32'(rv0), 32'd1);
      chk($sformatf("bp%0d_rdata", c), rd0, 32'h55AA55AA);
      chk($sformatf("bp%0d_err", c), 32'(err0), 32'd0);
      chk($sformatf("bp%0d_req_ready", c), 32'(rdy0), 32'd0);
      @(negedge clk);
    end
    vld = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done_valid", 32'(rv0), 32'd0);
    chk("bp_done_rdata", rd0, 32'h0);
    dbg0 = 8'd16;
    #1 chk("bp_ignored_store", dd0, 32'h55AA55AA);
    issue(1'b0, 1'b1, 32'h50, 32'h13579BDF, 4'hF);
    chk("rst_wait_valid", 32'(rv0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rv0), 32'd0);
    chk("rst_mid_ready", 32'(rdy0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rv0) seen++;
    end
    chk("rst_no_response", 32'(seen), 32'd0);
    chk("rst_release_ready", 32'(rdy0), 32'd1);
    xact('{1'b0, 1'b0, 32'h50, 32'h0, 4'hF, 32'h13579BDF, 1'b0, 2}, "rst_kept_store");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
